// File: rtl/dac_if_pkg.sv
// Shared types and default timing constants for the DAC DDR interface bring-up sequencer.
package dac_if_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST_DCM   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_IO_RST    = 3'd3,
        ST_TRAIN     = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    localparam int unsigned DEF_RST_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_STABLE   = 64;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 65536;
    localparam int unsigned DEF_IO_RST_CYCLES = 8;
    localparam int unsigned DEF_TRAIN_CYCLES  = 1024;
    localparam int unsigned DEF_MAX_RETRY     = 7;
    localparam int unsigned CNT_W             = 20;

endpackage

// File: rtl/dac_if_startup_ctrl_if.sv
// Control/status bundle between the bring-up sequencer and the clock wizard / DAC datapath.
interface dac_if_startup_ctrl_if;

    logic       enable;
    logic       dcm_locked;
    logic       dcm_reset;
    logic       io_reset;
    logic       train_en;
    logic       link_up;
    logic       fail;
    logic [2:0] state;
    logic [2:0] retry_cnt;
    logic [7:0] relock_cnt;

    modport master (
        input  enable,
        input  dcm_locked,
        output dcm_reset,
        output io_reset,
        output train_en,
        output link_up,
        output fail,
        output state,
        output retry_cnt,
        output relock_cnt
    );

    modport slave (
        output enable,
        output dcm_locked,
        input  dcm_reset,
        input  io_reset,
        input  train_en,
        input  link_up,
        input  fail,
        input  state,
        input  retry_cnt,
        input  relock_cnt
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single-bit level crossing into clk.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic meta_q;
    (* ASYNC_REG = "TRUE" *) logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/dac_if_startup_ctrl.sv
// Bring-up and supervision sequencer for the 5-to-2 DAC DDR interface: clock-wizard reset,
// lock qualification, OSERDES reset, training, and automatic relock with bounded retries.
module dac_if_startup_ctrl #(
    parameter int unsigned RST_CYCLES    = dac_if_pkg::DEF_RST_CYCLES,
    parameter int unsigned LOCK_STABLE   = dac_if_pkg::DEF_LOCK_STABLE,
    parameter int unsigned LOCK_TIMEOUT  = dac_if_pkg::DEF_LOCK_TIMEOUT,
    parameter int unsigned IO_RST_CYCLES = dac_if_pkg::DEF_IO_RST_CYCLES,
    parameter int unsigned TRAIN_CYCLES  = dac_if_pkg::DEF_TRAIN_CYCLES,
    parameter int unsigned MAX_RETRY     = dac_if_pkg::DEF_MAX_RETRY,
    parameter int unsigned CNT_W         = dac_if_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    dac_if_startup_ctrl_if.master bus
);

    import dac_if_pkg::*;

    localparam int unsigned STAB_W = $clog2(LOCK_STABLE + 1);

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [STAB_W-1:0]  stab_q, stab_nxt;
    logic [2:0]         retry_q, retry_nxt;
    logic [7:0]         relock_q, relock_nxt;
    logic               dcm_reset_q, io_reset_q, train_en_q, link_up_q, fail_q;
    logic               lk;

    sync_2ff #(
        .RST_VAL(1'b0)
    ) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.dcm_locked),
        .q     (lk)
    );

    // enable=0 overrides everything; lock completion beats a same-cycle timeout,
    // and lock loss beats counter expiry in IO_RST/TRAIN.
    always_comb begin
        state_nxt  = state_q;
        retry_nxt  = retry_q;
        relock_nxt = relock_q;
        stab_nxt   = '0;
        cnt_nxt    = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

        if (!bus.enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_nxt = ST_RST_DCM;
                ST_RST_DCM: begin
                    if (cnt_q == '0) state_nxt = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    stab_nxt = lk ? STAB_W'(stab_q + 1'b1) : '0;
                    if (lk && (stab_q == STAB_W'(LOCK_STABLE - 1))) begin
                        state_nxt = ST_IO_RST;
                    end else if (cnt_q == '0) begin
                        retry_nxt = retry_q + 1'b1;
                        state_nxt = (retry_nxt == 3'(MAX_RETRY)) ? ST_FAIL : ST_RST_DCM;
                    end
                end
                ST_IO_RST: begin
                    if (!lk)                state_nxt = ST_RST_DCM;
                    else if (cnt_q == '0)   state_nxt = ST_TRAIN;
                end
                ST_TRAIN: begin
                    if (!lk) begin
                        state_nxt = ST_RST_DCM;
                    end else if (cnt_q == '0) begin
                        state_nxt = ST_RUN;
                        retry_nxt = '0;
                    end
                end
                ST_RUN: begin
                    if (!lk) begin
                        state_nxt = ST_RST_DCM;
                        if (relock_q != '1) relock_nxt = relock_q + 1'b1;
                    end
                end
                ST_FAIL: state_nxt = ST_FAIL;
                default: state_nxt = ST_IDLE;
            endcase
        end

        if (state_nxt == ST_IDLE) retry_nxt = '0;

        if (state_nxt != state_q) begin
            case (state_nxt)
                ST_RST_DCM:   cnt_nxt = CNT_W'(RST_CYCLES - 1);
                ST_WAIT_LOCK: cnt_nxt = CNT_W'(LOCK_TIMEOUT - 1);
                ST_IO_RST:    cnt_nxt = CNT_W'(IO_RST_CYCLES - 1);
                ST_TRAIN:     cnt_nxt = CNT_W'(TRAIN_CYCLES - 1);
                default:      cnt_nxt = '0;
            endcase
        end
    end

    // Outputs decode the next state so they switch on the same edge as state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            stab_q      <= '0;
            retry_q     <= '0;
            relock_q    <= '0;
            dcm_reset_q <= 1'b1;
            io_reset_q  <= 1'b1;
            train_en_q  <= 1'b0;
            link_up_q   <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            stab_q      <= stab_nxt;
            retry_q     <= retry_nxt;
            relock_q    <= relock_nxt;
            dcm_reset_q <= (state_nxt == ST_IDLE) || (state_nxt == ST_RST_DCM) ||
                           (state_nxt == ST_FAIL);
            io_reset_q  <= (state_nxt != ST_TRAIN) && (state_nxt != ST_RUN);
            train_en_q  <= (state_nxt == ST_TRAIN);
            link_up_q   <= (state_nxt == ST_RUN);
            fail_q      <= (state_nxt == ST_FAIL);
        end
    end

    assign bus.dcm_reset  = dcm_reset_q;
    assign bus.io_reset   = io_reset_q;
    assign bus.train_en   = train_en_q;
    assign bus.link_up    = link_up_q;
    assign bus.fail       = fail_q;
    assign bus.state      = state_q;
    assign bus.retry_cnt  = retry_q;
    assign bus.relock_cnt = relock_q;

endmodule

// File: tb/tb_dac_if_startup_ctrl.sv
// Self-checking bench for dac_if_startup_ctrl: cycle model plus directed timing checks.
module tb_dac_if_startup_ctrl;

    localparam int unsigned P_RST    = 4;
    localparam int unsigned P_STABLE = 3;
    localparam int unsigned P_TMO    = 20;
    localparam int unsigned P_IORST  = 2;
    localparam int unsigned P_TRAIN  = 5;
    localparam int unsigned P_MAXR   = 2;

    logic clk = 1'b0;
    logic reset;
    bit   follow;
    bit   drop;
    logic pin_manual;

    int n_checks = 0;
    int n_errors = 0;

    dac_if_startup_ctrl_if bus();

    // Clock-wizard stand-in: in follow mode lock is lost while the wizard is held in reset.
    assign bus.dcm_locked = follow ? (!bus.dcm_reset && !drop) : pin_manual;

    dac_if_startup_ctrl #(
        .RST_CYCLES    (P_RST),
        .LOCK_STABLE   (P_STABLE),
        .LOCK_TIMEOUT  (P_TMO),
        .IO_RST_CYCLES (P_IORST),
        .TRAIN_CYCLES  (P_TRAIN),
        .MAX_RETRY     (P_MAXR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase number, elapsed cycles in phase, lock history as a delay line.
    int m_ph, m_t, m_stab, m_retry, m_relock;
    bit h1, h2, m_valid;

    always @(posedge clk) begin : model
        bit lk;
        int nph;
        if (reset) begin
            m_ph = 0; m_t = 0; m_stab = 0; m_retry = 0; m_relock = 0;
            h1 = 0; h2 = 0; m_valid = 1;
        end else begin
            lk = h2;
            h2 = h1;
            h1 = bus.dcm_locked;
            nph = m_ph;
            if (!bus.enable) nph = 0;
            else if (m_ph == 0) nph = 1;
            else if (m_ph == 1) begin
                if (m_t == P_RST - 1) nph = 2;
            end else if (m_ph == 2) begin
                m_stab = lk ? m_stab + 1 : 0;
                if (m_stab >= P_STABLE) nph = 3;
                else if (m_t == P_TMO - 1) begin
                    m_retry++;
                    nph = (m_retry == P_MAXR) ? 6 : 1;
                end
            end else if (m_ph >= 3 && m_ph <= 5 && !lk) begin
                nph = 1;
                if (m_ph == 5 && m_relock < 255) m_relock++;
            end else if (m_ph == 3 && m_t == P_IORST - 1) nph = 4;
            else if (m_ph == 4 && m_t == P_TRAIN - 1) begin
                nph = 5;
                m_retry = 0;
            end
            if (nph == 0) m_retry = 0;
            if (nph != m_ph) begin
                m_t = 0;
                m_stab = 0;
            end else begin
                m_t++;
            end
            m_ph = nph;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_state",     bus.state,      m_ph);
            chk("m_dcm_reset", bus.dcm_reset,  (m_ph == 0 || m_ph == 1 || m_ph == 6));
            chk("m_io_reset",  bus.io_reset,   (m_ph <= 3 || m_ph == 6));
            chk("m_train_en",  bus.train_en,   (m_ph == 4));
            chk("m_link_up",   bus.link_up,    (m_ph == 5));
            chk("m_fail",      bus.fail,       (m_ph == 6));
            chk("m_retry_cnt", bus.retry_cnt,  m_retry);
            chk("m_relock",    bus.relock_cnt, m_relock);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, input string name);
        int k = 0;
        while (bus.state !== s && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk(name, bus.state, s);
    endtask

    task automatic count_state(input logic [2:0] s, output int n);
        n = 0;
        while (bus.state === s && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},     bus.state,      0);
        chk({tag, "_dcm_reset"}, bus.dcm_reset,  1);
        chk({tag, "_io_reset"},  bus.io_reset,   1);
        chk({tag, "_train_en"},  bus.train_en,   0);
        chk({tag, "_link_up"},   bus.link_up,    0);
        chk({tag, "_fail"},      bus.fail,       0);
        chk({tag, "_retry"},     bus.retry_cnt,  0);
        chk({tag, "_relock"},    bus.relock_cnt, 0);
    endtask

    initial begin
        int n;
        int k;
        bus.enable = 1'b0;
        reset      = 1'b1;
        follow     = 1'b1;
        drop       = 1'b0;
        pin_manual = 1'b0;
        tick(3);
        chk_reset_vals("rst0");

        // Nominal bring-up with the wizard model.
        reset = 1'b0;
        bus.enable = 1'b1;
        wait_state(3'd1, 5, "t1_enter_rst_dcm");
        count_state(3'd1, n); chk("t1_rst_dcm_len",   n, 4);
        count_state(3'd2, n); chk("t1_wait_lock_len", n, 5);
        count_state(3'd3, n); chk("t1_io_rst_len",    n, 2);
        count_state(3'd4, n); chk("t1_train_len",     n, 5);
        chk("t1_link_up", bus.link_up, 1);
        chk("t1_retry",   bus.retry_cnt, 0);

        // Lock never asserts: two timeouts then FAIL.
        bus.enable = 1'b0;
        follow = 1'b0;
        pin_manual = 1'b0;
        tick(1);
        chk("t2_idle", bus.state, 0);
        bus.enable = 1'b1;
        wait_state(3'd1, 5, "t2_enter_rst_dcm");
        count_state(3'd1, n); chk("t2_rst1_len",  n, 4);
        count_state(3'd2, n); chk("t2_wait1_len", n, 20);
        chk("t2_retry1", bus.retry_cnt, 1);
        count_state(3'd1, n); chk("t2_rst2_len",  n, 4);
        count_state(3'd2, n); chk("t2_wait2_len", n, 20);
        chk("t2_fail_state", bus.state, 6);
        chk("t2_fail",       bus.fail, 1);
        chk("t2_dcm_reset",  bus.dcm_reset, 1);
        chk("t2_retry2",     bus.retry_cnt, 2);
        tick(10);
        chk("t2_fail_hold",  bus.state, 6);
        bus.enable = 1'b0;
        tick(1);
        chk("t2_idle_state", bus.state, 0);
        chk("t2_idle_fail",  bus.fail, 0);
        chk("t2_idle_retry", bus.retry_cnt, 0);

        // Lock glitch restarts the stability count.
        bus.enable = 1'b1;
        wait_state(3'd2, 20, "t3_enter_wait");
        pin_manual = 1'b1; tick(2);
        pin_manual = 1'b0; tick(1);
        pin_manual = 1'b1;
        k = 0;
        while (bus.state !== 3'd3 && k < 50) begin
            tick(1);
            k++;
        end
        chk("t3_io_rst_delay", k, 5);
        wait_state(3'd5, 50, "t3_reach_run");

        // Lock drop in RUN.
        pin_manual = 1'b0;
        tick(2);
        chk("t4_link_hold", bus.link_up, 1);
        tick(1);
        chk("t4_link_drop", bus.link_up, 0);
        chk("t4_relock1",   bus.relock_cnt, 1);
        chk("t4_rst_state", bus.state, 1);
        follow = 1'b1;
        wait_state(3'd5, 60, "t4_relink");
        chk("t4_link_back", bus.link_up, 1);
        for (int i = 0; i < 299; i++) begin
            drop = 1'b1;
            wait_state(3'd1, 10, "t4_loop_drop");
            drop = 1'b0;
            wait_state(3'd5, 60, "t4_loop_run");
        end
        chk("t4_relock_sat", bus.relock_cnt, 255);

        // enable=0 on the same cycle TRAIN would complete.
        drop = 1'b1;
        wait_state(3'd1, 10, "t5_drop");
        drop = 1'b0;
        wait_state(3'd4, 60, "t5_enter_train");
        tick(4);
        bus.enable = 1'b0;
        tick(1);
        chk("t5_state",    bus.state, 0);
        chk("t5_train_en", bus.train_en, 0);
        chk("t5_io_reset", bus.io_reset, 1);
        chk("t5_link_up",  bus.link_up, 0);
        chk("t5_relock",   bus.relock_cnt, 255);

        // Reset while in RUN.
        bus.enable = 1'b1;
        wait_state(3'd5, 60, "t6_reach_run");
        reset = 1'b1;
        tick(1);
        chk_reset_vals("t6");
        reset = 1'b0;
        bus.enable = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dac_if_startup_ctrl.md
Name: dac_if_startup_ctrl

Overview:
Bring-up and supervision sequencer for the 5-to-2 DAC DDR interface.
- Runs on a free-running system clock.
- Drives the clock-wizard reset and the OSERDES io_reset, qualifies dcm_locked, and holds the datapath on a training pattern before declaring the link up.
- Watches for loss of lock during operation and re-runs the sequence automatically, with bounded retries and status counters.

Parameters:
RST_CYCLES, 16, cycles dcm_reset is held high per attempt (>=1)
LOCK_STABLE, 64, consecutive synced-lock cycles required before proceeding (>=1)
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before an attempt counts as failed
IO_RST_CYCLES, 8, cycles io_reset is held high after lock qualifies (>=1)
TRAIN_CYCLES, 1024, cycles train_en is held high before RUN (>=1)
MAX_RETRY, 7, failed lock attempts tolerated before FAIL (1..7)
CNT_W, 20, width of the shared down-counter; must hold max(all cycle parameters)

Ports:
clk  in  1  system clock, free-running
reset  in  1  synchronous, active-high
enable  in  1  1 = run bring-up; 0 = return to IDLE
dcm_locked  in  1  asynchronous lock flag from clock wizard
dcm_reset  out  1  reset to clock wizard
io_reset  out  1  reset to OSERDES / output datapath
train_en  out  1  datapath selects training pattern when 1
link_up  out  1  interface running with live data
fail  out  1  retries exhausted
state  out  3  current state encoding, for debug
retry_cnt  out  3  failed attempts in the current bring-up
relock_cnt  out  8  lock losses seen in RUN, saturating

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values: state=IDLE, dcm_reset=1, io_reset=1, train_en=0, link_up=0, fail=0, retry_cnt=0, relock_cnt=0, lock synchronizer=0.
- Lock synchronizer: dcm_locked passes through a 2-flop synchronizer to give lk. All decisions use lk, so there are 2 cycles of latency from the pin.
- Registered outputs: all outputs are registered and decoded from the next state, so they change on the same edge as state.
- One shared down-counter (CNT_W bits) is loaded on every state entry.

State machine:
- IDLE (0): dcm_reset=1, io_reset=1. Moves to RST_DCM when enable=1. Entry from reset clears retry_cnt; entry via enable=0 also clears retry_cnt.
- RST_DCM (1): dcm_reset=1, io_reset=1. Counter is loaded with RST_CYCLES-1. On reaching 0, moves to WAIT_LOCK.
- WAIT_LOCK (2): dcm_reset=0, io_reset=1.
  - A stability counter counts consecutive lk=1 cycles and clears on lk=0.
  - On reaching LOCK_STABLE, moves to IO_RST.
  - Timeout counter is loaded with LOCK_TIMEOUT-1. If it reaches 0 first: retry_cnt++.
    - If retry_cnt (after increment) == MAX_RETRY, moves to FAIL.
    - Otherwise moves to RST_DCM.
  - If stability completion and timeout occur in the same cycle, the lock wins.
- IO_RST (3): dcm_reset=0, io_reset=1 for IO_RST_CYCLES, then moves to TRAIN.
- TRAIN (4): io_reset=0, train_en=1 for TRAIN_CYCLES, then moves to RUN and clears retry_cnt.
- RUN (5): link_up=1, train_en=0.
- Lock loss: lk=0 in IO_RST, TRAIN or RUN moves to RST_DCM on the next edge.
  - link_up and train_en drop on that same edge.
  - Only a loss in RUN increments relock_cnt, saturating at 255.
- FAIL (6): dcm_reset=1, io_reset=1, fail=1. Left only via enable=0 (to IDLE) or reset.
- enable=0 in any state moves to IDLE on the next edge. This has priority over every other transition, including the counter expiring in the same cycle.
- relock_cnt is cleared only by reset.

Decomposition:
- Shared package dac_if_pkg holds:
  - state typedef (3-bit enum, values as above);
  - default cycle constants;
  - CNT_W.
- One natural sub-module: sync_2ff, a generic 2-flop synchronizer used for dcm_locked. Mark the flops ASYNC_REG.
- The FSM, counters and output decode all live in the top module.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_STABLE=3, LOCK_TIMEOUT=20, IO_RST_CYCLES=2, TRAIN_CYCLES=5, MAX_RETRY=2.
1. Nominal bring-up: reset, then enable=1, dcm_locked tied 1 -> dcm_reset high for exactly 4 cycles. WAIT_LOCK lasts 3+2 sync cycles, io_reset stays high 2 more, then train_en high exactly 5 cycles. link_up=1, retry_cnt=0.
2. Lock never asserts -> two WAIT_LOCK timeouts of 20 cycles each, then FAIL with fail=1, dcm_reset=1, retry_cnt=2. Then enable=0 -> IDLE, fail=0, retry_cnt=0.
3. Lock glitch: lk high 2 cycles, low 1 cycle, then high -> stability counter restarts. Entry to IO_RST occurs 3 cycles after the final rise of lk.
4. Lock drop in RUN -> link_up falls 3 edges after the pin falls (2 sync + 1). relock_cnt goes 0->1. Sequence re-runs and link_up returns. Repeat 300 times -> relock_cnt holds at 255.
5. enable=0 mid-TRAIN, same cycle as counter expiry -> next state IDLE (not RUN), train_en=0, io_reset=1.
6. reset asserted in RUN -> next edge: all outputs at reset values, relock_cnt=0.
